// File: rtl/score_counter.sv
// score_counter: rhythm-game scorekeeper with combo doubling, saturating score and a play/pause/over FSM.
module score_counter #(
  parameter int PERFECT_PTS = 3,
  parameter int GOOD_PTS    = 1,
  parameter int COMBO_THR   = 10,
  parameter int MAX_SCORE   = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        song_end,
  input  logic        hit_valid,
  input  logic [1:0]  hit_grade,
  output logic [11:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;
  state_t cur, nxt;
  logic        restart, hit, miss, dbl;
  logic [7:0]  combo_inc;
  logic [12:0] base, pts, sum;
  logic [11:0] score_inc;
  always_comb begin
    nxt = (cur == IDLE || cur == OVER) ? (start ? PLAY : cur) :
          (cur == PLAY) ? (song_end ? OVER : pause ? PAUSE : PLAY) :
          (pause ? PLAY : PAUSE);
    restart   = start && (cur == IDLE || cur == OVER);
    hit       = hit_valid && cur == PLAY && (hit_grade == 2'b01 || hit_grade == 2'b10);
    miss      = hit_valid && cur == PLAY && hit_grade == 2'b00;
    combo_inc = (combo == 8'hff) ? combo : combo + 8'd1;
    dbl       = 32'(combo_inc) >= 32'(COMBO_THR);
    base      = hit_grade[1] ? 13'(PERFECT_PTS) : 13'(GOOD_PTS);
    pts       = dbl ? base << 1 : base;
    // 13-bit sum so the ceiling compare never sees a wrapped value
    sum       = {1'b0, score} + pts;
    score_inc = (sum > 13'(MAX_SCORE)) ? 12'(MAX_SCORE) : sum[11:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= IDLE;
      score     <= '0;
      combo     <= '0;
      max_combo <= '0;
    end else begin
      cur <= nxt;
      if (restart) begin
        score     <= '0;
        combo     <= '0;
        max_combo <= '0;
      end else if (hit) begin
        score     <= score_inc;
        combo     <= combo_inc;
        max_combo <= (combo_inc > max_combo) ? combo_inc : max_combo;
      end else if (miss) begin
        combo <= '0;
      end
    end
  end
  assign state = cur;
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed vectors against a default instance and a MAX_SCORE=50 instance.
module tb_score_counter;
  logic        clk, rst_n, start, pause, song_end, hit_valid;
  logic [1:0]  hit_grade;
  logic [11:0] score, score_b;
  logic [7:0]  combo, combo_b, max_combo, max_combo_b;
  logic [1:0]  state, state_b;
  int n_cmp = 0;
  int n_bad = 0;

  score_counter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .song_end(song_end),
    .hit_valid(hit_valid), .hit_grade(hit_grade), .score(score), .combo(combo),
    .max_combo(max_combo), .state(state)
  );
  score_counter #(.MAX_SCORE(50)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .song_end(song_end),
    .hit_valid(hit_valid), .hit_grade(hit_grade), .score(score_b), .combo(combo_b),
    .max_combo(max_combo_b), .state(state_b)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic p, input logic e, input logic v, input logic [1:0] g);
    start = s; pause = p; song_end = e; hit_valid = v; hit_grade = g;
    @(posedge clk);
    #1;
    start = 0; pause = 0; song_end = 0; hit_valid = 0; hit_grade = 2'b00;
  endtask

  initial begin
    rst_n = 0; start = 0; pause = 0; song_end = 0; hit_valid = 0; hit_grade = 2'b00;
    #12;
    chk("rst_state", state, 0);
    chk("rst_score", score, 0);
    rst_n = 1;
    cyc(1, 0, 0, 0, 2'b00);
    chk("start_after_rst", state, 1);
    repeat (12) cyc(0, 0, 0, 1, 2'b10);
    chk("p12_score", score, 45);
    chk("p12_combo", combo, 12);
    chk("p12_max", max_combo, 12);
    chk("p12_state", state, 1);
    chk("p12_score_b", score_b, 45);
    cyc(0, 0, 0, 1, 2'b00);
    chk("miss_combo", combo, 0);
    chk("miss_score", score, 45);
    chk("miss_max", max_combo, 12);
    cyc(0, 0, 0, 1, 2'b01);
    chk("good_combo", combo, 1);
    chk("good_max", max_combo, 12);
    chk("good_score", score, 46);
    cyc(1, 0, 0, 0, 2'b00);
    chk("start_in_play", score, 46);
    // saturation on the MAX_SCORE=50 instance
    cyc(0, 0, 1, 0, 2'b00);
    chk("over_state", state, 3);
    cyc(1, 0, 0, 0, 2'b00);
    chk("restart_state", state_b, 1);
    chk("restart_score", score, 0);
    chk("restart_max", max_combo, 0);
    repeat (13) cyc(0, 0, 0, 1, 2'b10);
    chk("sat13_b", score_b, 50);
    chk("nosat13", score, 51);
    repeat (7) cyc(0, 0, 0, 1, 2'b10);
    chk("sat20_b", score_b, 50);
    chk("combo20_b", combo_b, 20);
    chk("nosat20", score, 93);
    cyc(0, 0, 0, 1, 2'b11);
    chk("rsv_score", score, 93);
    chk("rsv_combo", combo, 20);
    chk("rsv_max", max_combo, 20);
    // pause behaviour
    cyc(0, 0, 1, 0, 2'b00);
    cyc(1, 0, 0, 0, 2'b00);
    repeat (2) cyc(0, 0, 0, 1, 2'b01);
    chk("g2_score", score, 2);
    cyc(0, 1, 0, 0, 2'b00);
    chk("paused", state, 2);
    repeat (3) cyc(0, 0, 0, 1, 2'b10);
    chk("pause_hits_score", score, 2);
    chk("pause_hits_combo", combo, 2);
    cyc(1, 0, 0, 0, 2'b00);
    cyc(0, 0, 1, 0, 2'b00);
    chk("pause_ign_start_end", state, 2);
    cyc(0, 1, 0, 0, 2'b00);
    chk("unpaused", state, 1);
    cyc(0, 0, 0, 1, 2'b01);
    chk("resume_score", score, 3);
    chk("resume_combo", combo, 3);
    // hit with song_end
    cyc(0, 0, 1, 1, 2'b10);
    chk("end_hit_score", score, 6);
    chk("end_hit_state", state, 3);
    cyc(0, 0, 0, 1, 2'b10);
    cyc(0, 1, 0, 0, 2'b00);
    chk("over_hold_score", score, 6);
    chk("over_ign_pause", state, 3);
    cyc(1, 0, 0, 0, 2'b00);
    chk("replay_state", state, 1);
    chk("replay_score", score, 0);
    chk("replay_combo", combo, 0);
    // song_end wins over pause, hit still counted
    cyc(0, 0, 0, 1, 2'b01);
    cyc(0, 1, 1, 1, 2'b01);
    chk("end_pause_state", state, 3);
    chk("end_pause_score", score, 2);
    // async reset mid-game with score 30
    cyc(1, 0, 0, 0, 2'b00);
    repeat (9) cyc(0, 0, 0, 1, 2'b10);
    cyc(0, 0, 0, 1, 2'b00);
    cyc(0, 0, 0, 1, 2'b10);
    chk("pre_rst_score", score, 30);
    hit_valid = 1; hit_grade = 2'b10;
    #2;
    rst_n = 0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_score", score, 0);
    chk("arst_combo", combo, 0);
    chk("arst_max", max_combo, 0);
    @(posedge clk);
    #2;
    hit_valid = 0; hit_grade = 2'b00;
    rst_n = 1;
    cyc(0, 0, 0, 1, 2'b10);
    chk("idle_hit_score", score, 0);
    chk("idle_hit_state", state, 0);
    cyc(1, 0, 0, 0, 2'b00);
    repeat (3) cyc(0, 0, 0, 1, 2'b11);
    chk("rsv3_state", state, 1);
    chk("rsv3_score", score, 0);
    chk("rsv3_combo", combo, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
